// File: rtl/frame_pkg.sv
// Shared definitions for the frame address generator: FSM encoding, tail-mode
// constants and the parameter legality rule used at elaboration.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int TAIL_DROP = 0;
  localparam int TAIL_PAD  = 1;

  // A hop larger than the frame would leave unread gaps between frames.
  function automatic bit frame_params_ok(input int frame_size, input int frame_hop,
                                         input int tail_mode);
    return (frame_size >= 1) && (frame_hop >= 1) && (frame_hop <= frame_size) &&
           ((tail_mode == TAIL_DROP) || (tail_mode == TAIL_PAD));
  endfunction

endpackage

// File: rtl/frame_tail_calc.sv
// Combinational frame geometry for one candidate frame start: whether it is the
// final frame, how far it runs past the window end, and whether the window is unusable.
module frame_tail_calc
  import frame_pkg::*;
#(
  parameter int ADDRW      = 32,
  parameter int FRAME_SIZE = 400,
  parameter int FRAME_HOP  = 160,
  parameter int TAIL_MODE  = TAIL_DROP
) (
  input  logic [ADDRW-1:0] start_addr,
  input  logic [ADDRW-1:0] end_addr,
  output logic             is_last,
  output logic [ADDRW-1:0] pad_len,
  output logic             too_short
);

  typedef logic [ADDRW:0] wide_t;

  localparam wide_t SIZE_W    = wide_t'(FRAME_SIZE);
  localparam wide_t SIZE_M1_W = wide_t'(FRAME_SIZE - 1);
  localparam wide_t HOP_W     = wide_t'(FRAME_HOP);

  // One extra bit so that running off the top of the address space reads as
  // "beyond end" instead of wrapping back into the window.
  wide_t start_w;
  wide_t end_w;
  wide_t len_w;
  wide_t frame_last_w;
  wide_t next_start_w;
  wide_t next_last_w;

  always_comb begin
    start_w      = {1'b0, start_addr};
    end_w        = {1'b0, end_addr};
    len_w        = end_w - start_w + wide_t'(1);
    frame_last_w = start_w + SIZE_M1_W;
    next_start_w = start_w + HOP_W;
    next_last_w  = next_start_w + SIZE_M1_W;
  end

  generate
    if (TAIL_MODE == TAIL_PAD) begin : g_pad
      always_comb begin
        too_short = (end_w < start_w);
        is_last   = (next_start_w > end_w);
        pad_len   = '0;
        if (frame_last_w > end_w) begin
          pad_len = ADDRW'(frame_last_w - end_w);
        end
      end
    end else begin : g_drop
      always_comb begin
        too_short = (end_w < start_w) || (len_w < SIZE_W);
        is_last   = (next_last_w > end_w);
        pad_len   = '0;
      end
    end
  endgenerate

endmodule

// File: rtl/frame_addr_gen.sv
// Frame address generator: walks a word window in hop-sized steps and hands one
// frame address pair per valid/ready handshake to the windowing stage's reader.
module frame_addr_gen
  import frame_pkg::*;
#(
  parameter int ADDRW      = 32,
  parameter int FRAME_SIZE = 400,
  parameter int FRAME_HOP  = 160,
  parameter int IDXW       = 16,
  parameter int TAIL_MODE  = TAIL_DROP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [ADDRW-1:0] i_start_addr,
  input  logic [ADDRW-1:0] i_end_addr,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [ADDRW-1:0] o_frame_start,
  output logic [ADDRW-1:0] o_frame_end,
  output logic [IDXW-1:0]  o_frame_idx,
  output logic [ADDRW-1:0] o_pad_len,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  generate
    if (!frame_params_ok(FRAME_SIZE, FRAME_HOP, TAIL_MODE)) begin : g_bad_params
      $error("frame_addr_gen: need 1 <= FRAME_HOP <= FRAME_SIZE and TAIL_MODE in {0,1}");
    end
  endgenerate

  localparam logic [ADDRW-1:0] HOP_A     = ADDRW'(FRAME_HOP);
  localparam logic [ADDRW-1:0] SIZE_M1_A = ADDRW'(FRAME_SIZE - 1);

  state_t           state_reg;
  logic             done_ph_reg;
  logic             err_pend_reg;
  logic [ADDRW-1:0] end_reg;

  logic [ADDRW-1:0] calc_start;
  logic [ADDRW-1:0] calc_end;
  logic [ADDRW-1:0] calc_pad;
  logic             calc_last;
  logic             calc_short;

  // In IDLE the calculator looks at the incoming window; in EMIT it looks one hop
  // ahead so the next frame is ready to load on the handshake edge.
  always_comb begin
    calc_start = i_start_addr;
    calc_end   = i_end_addr;
    if (state_reg != ST_IDLE) begin
      calc_start = o_frame_start + HOP_A;
      calc_end   = end_reg;
    end
  end

  frame_tail_calc #(
    .ADDRW      (ADDRW),
    .FRAME_SIZE (FRAME_SIZE),
    .FRAME_HOP  (FRAME_HOP),
    .TAIL_MODE  (TAIL_MODE)
  ) u_tail (
    .start_addr (calc_start),
    .end_addr   (calc_end),
    .is_last    (calc_last),
    .pad_len    (calc_pad),
    .too_short  (calc_short)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      done_ph_reg   <= 1'b0;
      err_pend_reg  <= 1'b0;
      end_reg       <= '0;
      o_valid       <= 1'b0;
      o_frame_start <= '0;
      o_frame_end   <= '0;
      o_frame_idx   <= '0;
      o_pad_len     <= '0;
      o_last        <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            end_reg     <= i_end_addr;
            o_busy      <= 1'b1;
            done_ph_reg <= 1'b0;
            if (calc_short) begin
              err_pend_reg <= 1'b1;
              state_reg    <= ST_DONE;
            end else begin
              err_pend_reg  <= 1'b0;
              o_valid       <= 1'b1;
              o_frame_start <= calc_start;
              o_frame_end   <= calc_start + SIZE_M1_A;
              o_frame_idx   <= '0;
              o_pad_len     <= calc_pad;
              o_last        <= calc_last;
              state_reg     <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          // Abort takes priority, even over the handshake on the final frame.
          if (i_abort) begin
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_busy    <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (i_ready) begin
            if (o_last) begin
              o_valid      <= 1'b0;
              o_last       <= 1'b0;
              err_pend_reg <= 1'b0;
              done_ph_reg  <= 1'b0;
              state_reg    <= ST_DONE;
            end else begin
              o_frame_start <= calc_start;
              o_frame_end   <= calc_start + SIZE_M1_A;
              o_frame_idx   <= o_frame_idx + 1'b1;
              o_pad_len     <= calc_pad;
              o_last        <= calc_last;
            end
          end
        end
        ST_DONE: begin
          // Two phases: arm the done pulse, then leave while it is visible.
          if (!done_ph_reg) begin
            done_ph_reg <= 1'b1;
            o_done      <= 1'b1;
            o_err       <= err_pend_reg;
          end else begin
            done_ph_reg  <= 1'b0;
            err_pend_reg <= 1'b0;
            o_busy       <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          o_valid   <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_addr_gen.sv
// Drives a drop-tail and a pad-tail generator with the same window stimulus and
// compares both every cycle against frame lists computed directly from the window.
module tb_frame_addr_gen;

  localparam int AW = 32;
  localparam int FS = 4;
  localparam int FH = 2;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          i_abort;
  logic          i_ready;
  logic [AW-1:0] i_start_addr;
  logic [AW-1:0] i_end_addr;

  logic [1:0]    valid_w, last_w, busy_w, done_w, err_w;
  logic [AW-1:0] fs_w [2];
  logic [AW-1:0] fe_w [2];
  logic [AW-1:0] pad_w [2];
  logic [IW-1:0] idx_w [2];

  frame_addr_gen #(.ADDRW(AW), .FRAME_SIZE(FS), .FRAME_HOP(FH), .IDXW(IW), .TAIL_MODE(0)) u_dut_drop (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_start_addr(i_start_addr), .i_end_addr(i_end_addr), .i_ready(i_ready),
    .o_valid(valid_w[0]), .o_frame_start(fs_w[0]), .o_frame_end(fe_w[0]),
    .o_frame_idx(idx_w[0]), .o_pad_len(pad_w[0]), .o_last(last_w[0]),
    .o_busy(busy_w[0]), .o_done(done_w[0]), .o_err(err_w[0])
  );

  frame_addr_gen #(.ADDRW(AW), .FRAME_SIZE(FS), .FRAME_HOP(FH), .IDXW(IW), .TAIL_MODE(1)) u_dut_pad (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_start_addr(i_start_addr), .i_end_addr(i_end_addr), .i_ready(i_ready),
    .o_valid(valid_w[1]), .o_frame_start(fs_w[1]), .o_frame_end(fe_w[1]),
    .o_frame_idx(idx_w[1]), .o_pad_len(pad_w[1]), .o_last(last_w[1]),
    .o_busy(busy_w[1]), .o_done(done_w[1]), .o_err(err_w[1])
  );

  always #5 clk = ~clk;

  // Reference: per DUT (0 = drop, 1 = pad) the full list of frames for the window.
  longint unsigned m_start [2][64];
  longint unsigned m_pad   [2][64];
  int              m_nfr [2];
  int              m_ptr [2];
  bit              m_active [2];
  int              m_cd [2];
  bit              m_err [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic void build(input int d, input logic [31:0] s, input logic [31:0] e);
    longint unsigned su, eu, fs;
    su = 64'(s);
    eu = 64'(e);
    m_nfr[d] = 0;
    if (eu >= su) begin
      for (int k = 0; k < 64; k++) begin
        fs = su + 64'(FH * k);
        if ((d == 0) ? (fs + FS - 1 <= eu) : (fs <= eu)) begin
          m_start[d][k] = fs;
          m_pad[d][k]   = (fs + FS - 1 > eu) ? (fs + FS - 1 - eu) : 64'd0;
          m_nfr[d]      = k + 1;
        end else begin
          break;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_cd[d]     = 0;
      m_err[d]    = 1'b0;
      m_ptr[d]    = 0;
      m_nfr[d]    = 0;
    end
  endfunction

  // Done pulse appears two cycles after the completing event (start error or last handshake).
  function automatic void model_edge();
    for (int d = 0; d < 2; d++) begin
      if (m_cd[d] > 0) begin
        m_cd[d]--;
      end else if (m_active[d]) begin
        if (i_abort) begin
          m_active[d] = 1'b0;
        end else if (i_ready) begin
          if (m_ptr[d] == m_nfr[d] - 1) begin
            m_active[d] = 1'b0;
            m_cd[d]     = 2;
            m_err[d]    = 1'b0;
          end else begin
            m_ptr[d]++;
          end
        end
      end else if (i_start) begin
        build(d, i_start_addr, i_end_addr);
        m_ptr[d] = 0;
        if (m_nfr[d] == 0) begin
          m_cd[d]  = 2;
          m_err[d] = 1'b1;
        end else begin
          m_active[d] = 1'b1;
        end
      end
    end
  endfunction

  function automatic bit model_busy();
    return m_active[0] || m_active[1] || (m_cd[0] > 0) || (m_cd[1] > 0);
  endfunction

  task automatic check_all();
    int p;
    for (int d = 0; d < 2; d++) begin
      chk("valid", d, 64'(valid_w[d]), 64'(m_active[d]));
      chk("busy", d, 64'(busy_w[d]), 64'(m_active[d] || (m_cd[d] > 0)));
      chk("done", d, 64'(done_w[d]), 64'(m_cd[d] == 1));
      chk("err", d, 64'(err_w[d]), 64'((m_cd[d] == 1) && m_err[d]));
      if (m_active[d]) begin
        p = m_ptr[d];
        chk("frame_start", d, 64'(fs_w[d]), m_start[d][p] & 64'hFFFF_FFFF);
        chk("frame_end", d, 64'(fe_w[d]), (m_start[d][p] + FS - 1) & 64'hFFFF_FFFF);
        chk("frame_idx", d, 64'(idx_w[d]), 64'(p) & 64'hFFFF);
        chk("pad_len", d, 64'(pad_w[d]), m_pad[d][p]);
        chk("last", d, 64'(last_w[d]), 64'(p == m_nfr[d] - 1));
      end
    end
  endtask

  task automatic check_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", d, 64'(valid_w[d]), 64'd0);
      chk("rst_start", d, 64'(fs_w[d]), 64'd0);
      chk("rst_end", d, 64'(fe_w[d]), 64'd0);
      chk("rst_idx", d, 64'(idx_w[d]), 64'd0);
      chk("rst_pad", d, 64'(pad_w[d]), 64'd0);
      chk("rst_last", d, 64'(last_w[d]), 64'd0);
      chk("rst_busy", d, 64'(busy_w[d]), 64'd0);
      chk("rst_done", d, 64'(done_w[d]), 64'd0);
      chk("rst_err", d, 64'(err_w[d]), 64'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // rmode: 0 ready high, 1 random ready, 2 stall idx 2 for three cycles.
  task automatic run_window(input logic [31:0] s, input logic [31:0] e, input int rmode,
                            input int abort_at, input int restart_at);
    int held = 0;
    bit drained;
    i_start_addr = s;
    i_end_addr   = e;
    i_start      = 1'b1;
    i_ready      = 1'b1;
    i_abort      = 1'b0;
    step();
    i_start = 1'b0;
    for (int n = 0; n < 300 && model_busy(); n++) begin
      i_ready = 1'b1;
      i_abort = 1'b0;
      i_start = 1'b0;
      if (rmode == 1) i_ready = ($urandom_range(0, 3) != 0);
      if (rmode == 2 && m_active[0] && m_ptr[0] == 2 && held < 3) begin
        i_ready = 1'b0;
        held++;
      end
      if (abort_at >= 0 && m_active[0] && m_ptr[0] == abort_at) i_abort = 1'b1;
      if (n == restart_at) begin
        i_start      = 1'b1;
        i_start_addr = s + 32'h40;
      end
      step();
    end
    drained = !model_busy();
    checks++;
    assert (drained) else begin
      errors++;
      $error("FAIL window_timeout observed=busy expected=idle start=%0h end=%0h", s, e);
    end
    $display("window start=%08h end=%08h rmode=%0d abort_at=%0d frames drop=%0d pad=%0d",
             s, e, rmode, abort_at, m_nfr[0], m_nfr[1]);
    i_start = 1'b0;
    i_abort = 1'b0;
    i_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    logic [31:0] rs, re;
    int len;
    rst          = 1'b0;
    i_start      = 1'b0;
    i_abort      = 1'b0;
    i_ready      = 1'b1;
    i_start_addr = '0;
    i_end_addr   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b1;
    step();

    run_window(32'h100, 32'h10B, 0, -1, -1);
    run_window(32'h100, 32'h10B, 2, -1, -1);
    run_window(32'h0, 32'h2, 0, -1, -1);
    run_window(32'h0, 32'h3, 0, -1, -1);
    run_window(32'hFFFF_FFF8, 32'hFFFF_FFFF, 0, -1, -1);
    run_window(32'h100, 32'h10B, 0, 2, 1);
    run_window(32'h0, 32'h3, 0, 0, -1);
    run_window(32'h20, 32'h10, 0, -1, -1);

    // Asynchronous reset in the middle of a window.
    i_start_addr = 32'h200;
    i_end_addr   = 32'h220;
    i_start      = 1'b1;
    step();
    i_start = 1'b0;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_reset();
    @(posedge clk);
    #1;
    check_reset();
    rst = 1'b1;
    step();

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) rs = 32'hFFFF_FFE8 + 32'($urandom_range(0, 23));
      else rs = $urandom;
      len = int'($urandom_range(0, 33)) - 3;
      re  = rs + 32'(len);
      run_window(rs, re, int'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
